// File: rtl/pipelined_register_file_if.sv
// Bus between decode/writeback (master) and the register file (slave):
// two read ports, one write port, reservations and hazard status.
interface pipelined_register_file_if #(
  parameter int unsigned ADDR_BUS_WIDTH = 5,
  parameter int unsigned DATA_BUS_WIDTH = 32
);
  logic [ADDR_BUS_WIDTH-1:0] addr1;
  logic [ADDR_BUS_WIDTH-1:0] addr2;
  logic [DATA_BUS_WIDTH-1:0] read_data1;
  logic [DATA_BUS_WIDTH-1:0] read_data2;
  logic [ADDR_BUS_WIDTH-1:0] addr3;
  logic [DATA_BUS_WIDTH-1:0] write_data;
  logic                      write_en;
  logic                      reserve_en;
  logic [ADDR_BUS_WIDTH-1:0] addr_rsv;
  logic                      busy1;
  logic                      busy2;
  logic                      pend_overflow;

  modport master (
    output addr1, addr2, addr3, write_data, write_en, reserve_en, addr_rsv,
    input  read_data1, read_data2, busy1, busy2, pend_overflow
  );

  modport slave (
    input  addr1, addr2, addr3, write_data, write_en, reserve_en, addr_rsv,
    output read_data1, read_data2, busy1, busy2, pend_overflow
  );
endinterface

// File: rtl/pipelined_register_file.sv
// 2R/1W register file with write-to-read bypass, optional zero register and
// per-register pending-write counters for read-after-write hazard detection.
module pipelined_register_file #(
  parameter int unsigned ADDR_BUS_WIDTH = 5,
  parameter int unsigned DATA_BUS_WIDTH = 32,
  parameter bit          ZERO_REG_EN    = 1'b1,
  parameter bit          BYPASS_EN      = 1'b1,
  parameter int unsigned PEND_WIDTH     = 2
) (
  input logic                     clk,
  input logic                     rst,
  pipelined_register_file_if.slave rf
);

  localparam int unsigned DEPTH = 2 ** ADDR_BUS_WIDTH;
  localparam logic [PEND_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [PEND_WIDTH-1:0] CNT_ONE = PEND_WIDTH'(1);

  logic [DATA_BUS_WIDTH-1:0] mem_q [DEPTH];
  logic [PEND_WIDTH-1:0]     cnt_q [DEPTH];
  logic [PEND_WIDTH-1:0]     cnt_d [DEPTH];
  logic                      ovf_q;
  logic                      ovf_d;
  logic [DEPTH-1:0]          inc;
  logic [DEPTH-1:0]          dec;

  // One-hot reserve/retire selects; dec doubles as the storage write enable
  // so the zero register is excluded from both in one place.
  always_comb begin
    inc = '0;
    dec = '0;
    inc[rf.addr_rsv] = rf.reserve_en;
    dec[rf.addr3]    = rf.write_en;
    if (ZERO_REG_EN) begin
      inc[0] = 1'b0;
      dec[0] = 1'b0;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc[r] && !dec[r]) begin
        if (cnt_q[r] == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + CNT_ONE;
        end
      end else if (dec[r] && !inc[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      ovf_q <= ovf_d;
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (dec[i]) begin
          mem_q[i] <= rf.write_data;
        end
      end
    end
  end

  logic [ADDR_BUS_WIDTH-1:0] rd_addr [2];

  assign rd_addr[0] = rf.addr1;
  assign rd_addr[1] = rf.addr2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic                      is_zero;
    logic                      fwd;
    logic [DATA_BUS_WIDTH-1:0] data;
    logic                      busy;
    logic [PEND_WIDTH-1:0]     cnt;

    assign is_zero = ZERO_REG_EN && (rd_addr[p] == '0);
    assign fwd     = BYPASS_EN && rf.write_en && (rf.addr3 == rd_addr[p]);
    assign cnt     = cnt_q[rd_addr[p]];

    // A port stops reporting busy when the last outstanding write is the
    // one being forwarded to it this cycle.
    always_comb begin
      if (is_zero) begin
        data = '0;
      end else if (fwd) begin
        data = rf.write_data;
      end else begin
        data = mem_q[rd_addr[p]];
      end
      busy = !is_zero && (cnt != '0) && !(fwd && (cnt == CNT_ONE));
    end
  end

  assign rf.read_data1    = g_rd[0].data;
  assign rf.read_data2    = g_rd[1].data;
  assign rf.busy1         = g_rd[0].busy;
  assign rf.busy2         = g_rd[1].busy;
  assign rf.pend_overflow = ovf_q;

endmodule

// File: doc/pipelined_register_file.md
# pipelined_register_file

Parametrised general-purpose register file for the pipelined core. It keeps two asynchronous read ports and one write port, and adds three things: synchronous clear, write-to-read bypass, and an optional hard-wired zero register. A per-register pending-write scoreboard lets the issue stage detect read-after-write hazards against in-flight instructions. It sits between decode (reads, reservations) and writeback (writes, retirements).

## Interface
Parameters:
- ADDR_BUS_WIDTH, 5, register address width; depth = 2**ADDR_BUS_WIDTH.
- DATA_BUS_WIDTH, 32, register data width.
- ZERO_REG_EN, 1, when 1 register 0 always reads 0; writes and reservations to it are ignored.
- BYPASS_EN, 1, when 1 a same-cycle write is forwarded to matching read ports.
- PEND_WIDTH, 2, width of each per-register pending-write counter; maximum count = 2**PEND_WIDTH-1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- addr1  in  ADDR_BUS_WIDTH  read port 1 address.
- addr2  in  ADDR_BUS_WIDTH  read port 2 address.
- read_data1  out  DATA_BUS_WIDTH  read port 1 data (combinational).
- read_data2  out  DATA_BUS_WIDTH  read port 2 data (combinational).
- addr3  in  ADDR_BUS_WIDTH  write address.
- write_data  in  DATA_BUS_WIDTH  write data.
- write_en  in  1  write strobe; also retires one pending write on addr3.
- reserve_en  in  1  issue stage marks addr_rsv as having a pending write.
- addr_rsv  in  ADDR_BUS_WIDTH  register being reserved.
- busy1  out  1  addr1 has an outstanding write (combinational).
- busy2  out  1  addr2 has an outstanding write (combinational).
- pend_overflow  out  1  sticky flag: a reservation hit a saturated counter.

## Operation
- Storage: mem[0..depth-1] of DATA_BUS_WIDTH bits, plus cnt[0..depth-1] of PEND_WIDTH bits.
- Read path, port n:
  - If ZERO_REG_EN and addrn==0, the port returns 0.
  - Else if BYPASS_EN and write_en and addr3==addrn, it returns write_data.
  - Else it returns mem[addrn].
- Write: on the rising edge with write_en=1, mem[addr3] <= write_data. The write is suppressed when ZERO_REG_EN and addr3==0.
- Scoreboard update per register r, each cycle:
  - inc = reserve_en && addr_rsv==r.
  - dec = write_en && addr3==r.
  - inc && !dec: cnt+1. If cnt is already at max, cnt holds and pend_overflow <= 1.
  - dec && !inc: cnt-1. If cnt is already 0, cnt holds at 0 (no underflow, write still lands).
  - inc && dec: cnt unchanged.
  - Register 0 never counts when ZERO_REG_EN.
- busyn = (cnt[addrn] != 0), except in two cases:
  - It is 0 when BYPASS_EN, write_en, addr3==addrn and cnt[addrn]==1, because the final write is forwarded this cycle.
  - It is 0 for addrn==0 when ZERO_REG_EN.
- A same-cycle reserve never affects busy1/busy2; the count only changes at the next edge.
- pend_overflow is cleared only by rst.

## Timing
- Read latency is 0 cycles (combinational). A write becomes visible in mem the cycle after the edge, or the same cycle through the bypass.
- Reset (rst=1 at an edge):
  - All mem entries and all cnt entries become 0, and pend_overflow becomes 0.
  - write_en and reserve_en are ignored in that cycle.
- Outputs after reset: read_data1/2 = 0, busy1/2 = 0, pend_overflow = 0.
- Reset asserted mid-operation discards all pending counts; in-flight writebacks arriving afterwards write normally and do not underflow.
- Read data and busy outputs depend combinationally on addr1/addr2/addr3/write_en/write_data. There is no combinational path from reserve_en to any output.

## Test plan
- Reset then read all addresses -> every read_data = 0, busy = 0, pend_overflow = 0.
- Write 0xDEADBEEF to r5 with addr1=5 in the same cycle -> read_data1 = 0xDEADBEEF that cycle (BYPASS_EN=1); with BYPASS_EN=0 the value appears only the next cycle.
- Write 0x12345678 to r0 with ZERO_REG_EN=1 -> read_data1 for addr1=0 stays 0; reserve r0 -> busy1 stays 0.
- Reserve r7 twice, then write r7 once -> busy1 (addr1=7) stays 1. Second write -> busy1 = 0 in the write cycle; read_data1 = forwarded data.
- Reserve r3 four times with PEND_WIDTH=2 -> cnt = 3 and pend_overflow = 1. Then reserve and write r3 in the same cycle -> cnt stays 3.
- Reserve r9 and write r9 = 0xA, then assert rst for one cycle -> busy = 0 and read_data = 0. A following write to r9 succeeds and busy stays 0.
